muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) in the execute stage.
- Accepts one operation per START pulse and runs a registered multiply or a 32-step iterative restoring division.
- Drives BUSY so the pipeline stalls, then pulses RESULT_VALID with the result.
- Handles the RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/muldiv_sequencer.sv | 168 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : RV32M multiply / restoring-divide sequencer (execute stage)
// Revision: 1.0
// ============================================================================
module muldiv_sequencer #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  select,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic        flush,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] result
);

   localparam logic [4:0] c_MUL    = 5'h10;
   localparam logic [4:0] c_MULH   = 5'h11;
   localparam logic [4:0] c_MULHSU = 5'h12;
   localparam logic [4:0] c_MULHU  = 5'h13;
   localparam logic [4:0] c_DIV    = 5'h14;
   localparam logic [4:0] c_DIVU   = 5'h15;
   localparam logic [4:0] c_REM    = 5'h16;
   localparam logic [4:0] c_REMU   = 5'h17;
   localparam logic [4:0] c_LAST   = 5'(DIV_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL     = 3'd1,
      S_DIV_RUN = 3'd2,
      S_DIV_FIX = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t      r_state;
   logic [4:0]  r_sel;
   logic [31:0] r_op1, r_op2;
   logic [31:0] r_quo, r_rem, r_dvs;
   logic [4:0]  r_cnt;
   logic        r_busy, r_valid;
   logic [31:0] r_result;

   // Decode of the incoming request, used only on the accept edge
   logic        w_in_mul, w_in_div, w_in_signed, w_in_rem, w_overflow;
   logic [31:0] w_abs1, w_abs2;
   assign w_in_mul    = (select == c_MUL) || (select == c_MULH) ||
                        (select == c_MULHSU) || (select == c_MULHU);
   assign w_in_div    = (select == c_DIV) || (select == c_DIVU) ||
                        (select == c_REM) || (select == c_REMU);
   assign w_in_signed = (select == c_DIV) || (select == c_REM);
   assign w_in_rem    = (select == c_REM) || (select == c_REMU);
   assign w_overflow  = w_in_signed && (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);
   assign w_abs1      = (w_in_signed && data1[31]) ? -data1 : data1;
   assign w_abs2      = (w_in_signed && data2[31]) ? -data2 : data2;

   // Multiply on latched operands; only MULHU treats DATA1 as unsigned
   logic        w_a_signed, w_b_signed;
   logic [63:0] w_mul_a, w_mul_b, w_prod;
   assign w_a_signed = (r_sel != c_MULHU);
   assign w_b_signed = (r_sel == c_MUL) || (r_sel == c_MULH);
   assign w_mul_a    = {{32{w_a_signed & r_op1[31]}}, r_op1};
   assign w_mul_b    = {{32{w_b_signed & r_op2[31]}}, r_op2};
   assign w_prod     = w_mul_a * w_mul_b;

   // One restoring step: r_quo shifts dividend bits out and quotient bits in
   logic [32:0] w_shift, w_trial;
   logic        w_fit;
   assign w_shift = {r_rem, r_quo[31]};
   assign w_trial = w_shift - {1'b0, r_dvs};
   assign w_fit   = ~w_trial[32];

   logic        w_sgn_div, w_is_rem;
   logic [31:0] w_quo_fix, w_rem_fix;
   assign w_sgn_div = (r_sel == c_DIV) || (r_sel == c_REM);
   assign w_is_rem  = (r_sel == c_REM) || (r_sel == c_REMU);
   assign w_quo_fix = (w_sgn_div && (r_op1[31] ^ r_op2[31])) ? -r_quo : r_quo;
   assign w_rem_fix = (w_sgn_div && r_op1[31]) ? -r_rem : r_rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sel    <= 5'd0;
         r_op1    <= 32'd0;
         r_op2    <= 32'd0;
         r_quo    <= 32'd0;
         r_rem    <= 32'd0;
         r_dvs    <= 32'd0;
         r_cnt    <= 5'd0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= 32'd0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (start) begin
                  r_sel <= select;
                  r_op1 <= data1;
                  r_op2 <= data2;
                  if (w_in_mul) begin
                     r_state <= S_MUL;
                     r_busy  <= 1'b1;
                  end else if (w_in_div && (data2 == 32'd0)) begin
                     r_result <= w_in_rem ? data1 : 32'hFFFF_FFFF;
                     r_state  <= S_DONE;
                     r_valid  <= 1'b1;
                  end else if (w_overflow) begin
                     r_result <= w_in_rem ? 32'd0 : 32'h8000_0000;
                     r_state  <= S_DONE;
                     r_valid  <= 1'b1;
                  end else if (w_in_div) begin
                     r_quo   <= w_abs1;
                     r_dvs   <= w_abs2;
                     r_rem   <= 32'd0;
                     r_cnt   <= 5'd0;
                     r_state <= S_DIV_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_result <= 32'd0;
                     r_state  <= S_DONE;
                     r_valid  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_result <= (r_sel == c_MUL) ? w_prod[31:0] : w_prod[63:32];
               r_state  <= S_DONE;
               r_busy   <= 1'b0;
               r_valid  <= 1'b1;
            end
            S_DIV_RUN: begin
               r_rem <= w_fit ? w_trial[31:0] : w_shift[31:0];
               r_quo <= {r_quo[30:0], w_fit};
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == c_LAST) begin
                  r_state <= S_DIV_FIX;
               end
            end
            S_DIV_FIX: begin
               r_result <= w_is_rem ? w_rem_fix : w_quo_fix;
               r_state  <= S_DONE;
               r_busy   <= 1'b0;
               r_valid  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign result_valid = r_valid;
   assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// tb_muldiv_sequencer : arithmetic reference model checked every cycle, plus
// directed operations with hand-computed results, latencies and busy counts.
module tb_muldiv_sequencer;

   localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
   localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [4:0]  select;
   logic [31:0] data1, data2;
   logic        busy, result_valid;
   logic [31:0] result;

   always #5 clk = ~clk;

   muldiv_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .select       (select),
      .data1        (data1),
      .data2        (data2),
      .flush        (flush),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_acc  = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of an RV32M operation
   function automatic logic [31:0] ref_res(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
      longint          p;
      longint unsigned pu;
      logic [63:0]     pv;
      int              sa, sb;
      sa = a;
      sb = b;
      case (s)
         MUL:    begin p = longint'(sa) * longint'(sb); pv = p; return pv[31:0]; end
         MULH:   begin p = longint'(sa) * longint'(sb); pv = p; return pv[63:32]; end
         MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); pv = p; return pv[63:32]; end
         MULHU:  begin pu = {32'd0, a}; pu = pu * {32'd0, b}; pv = pu; return pv[63:32]; end
         DIV:    begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         REM:    begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REMU:   return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Number of cycles BUSY is high for an accepted request
   function automatic int busy_len(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
      if (s == MUL || s == MULH || s == MULHSU || s == MULHU) return 1;
      if (s == DIV || s == DIVU || s == REM || s == REMU) begin
         if (b == 0) return 0;
         if ((s == DIV || s == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
         return 33;
      end
      return 0;
   endfunction

   // Reference model: expected outputs after each rising edge
   int          m_left = 0;
   logic        m_busy, m_valid;
   logic [31:0] m_result, m_pending;

   always @(posedge clk) begin
      if (reset) begin
         m_left <= 0; m_busy <= 1'b0; m_valid <= 1'b0; m_result <= 32'd0;
      end else if (flush) begin
         m_left <= 0; m_busy <= 1'b0; m_valid <= 1'b0;
      end else if (m_left > 1) begin
         m_left <= m_left - 1; m_valid <= 1'b0;
      end else if (m_left == 1) begin
         m_left <= 0; m_busy <= 1'b0; m_valid <= 1'b1; m_result <= m_pending;
      end else begin
         m_valid <= 1'b0;
         if (start) begin
            if (busy_len(select, data1, data2) == 0) begin
               m_valid  <= 1'b1;
               m_result <= ref_res(select, data1, data2);
            end else begin
               m_left    <= busy_len(select, data1, data2);
               m_busy    <= 1'b1;
               m_pending <= ref_res(select, data1, data2);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'd0, busy}, {31'd0, m_busy});
         check("result_valid", {31'd0, result_valid}, {31'd0, m_valid});
         check("result", result, m_result);
      end
   end

   task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; select = s; data1 = a; data2 = b;
      @(negedge clk);
      start = 1'b0;
      t_acc = cyc;
   endtask

   task automatic wait_result(input string name, input logic [31:0] exp, input int lat, input int nbusy);
      int k  = 0;
      int nb = 0;
      while (!result_valid && k < 200) begin
         if (busy) nb++;
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: timeout, no result_valid within 200 cycles", name);
      end else begin
         check(name, result, exp);
         check({name, "_latency"}, cyc - t_acc, lat);
         if (nbusy >= 0) check({name, "_busy_cycles"}, nb, nbusy);
      end
   endtask

   task automatic run(input string name, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input int nbusy);
      issue(s, a, b);
      wait_result(name, exp, lat, nbusy);
   endtask

   task automatic no_pulse(input string name, input int n);
      int p = 0;
      repeat (n) begin
         @(negedge clk);
         if (result_valid) p++;
      end
      check(name, p, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; select = 5'd0; data1 = 32'd0; data2 = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_valid", {31'd0, result_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      chk_en = 1'b1;
      reset  = 1'b0;
      @(negedge clk);

      run("mulh_131073", MULH, 32'd131073, 32'd131073, 32'd4, 1, 1);
      run("mul_4x5", MUL, 32'd4, 32'd5, 32'd20, 1, 1);
      run("mulhsu_m1x2", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, 1);
      run("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1);
      run("div_m7_2", DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, 33);
      run("rem_m7_2", REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33, 33);
      run("div_7_m2", DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33, 33);
      run("rem_7_m2", REM, 32'd7, -32'sd2, 32'd1, 33, 33);
      @(negedge clk);
      run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33, 33);
      run("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33, 33);
      run("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 33);
      run("div_by_zero", DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0, 0);
      run("remu_by_zero", REMU, 32'h1234, 32'd0, 32'h1234, 0, 0);
      run("div_overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
      run("rem_overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0);
      run("non_m_select", 5'h03, 32'd9, 32'd9, 32'd0, 0, 0);

      // START while busy is ignored
      @(negedge clk);
      issue(DIV, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      start = 1'b1; select = DIV; data1 = 32'd50; data2 = 32'd5;
      @(negedge clk);
      start = 1'b0;
      wait_result("div_ignore_restart", 32'd14, 33, -1);

      // Back-to-back issue from DONE
      run("b2b_first", DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, 33);
      run("b2b_second", REMU, 32'd100, 32'd7, 32'd2, 33, 33);

      // FLUSH mid-divide
      @(negedge clk);
      issue(DIV, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_valid", {31'd0, result_valid}, 32'd0);
      check("flush_result_held", result, 32'd2);
      no_pulse("flush_no_pulse", 40);
      run("after_flush_divu", DIVU, 32'd100, 32'd7, 32'd14, 33, 33);

      // RESET mid-divide
      @(negedge clk);
      issue(DIV, 32'd1000, 32'd3);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_result", result, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
      no_pulse("rst_no_stale_pulse", 40);

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
